ps2_kbd_rx: RTL and testbench

Parametrised PS/2 keyboard receiver: conditions raw PS/2 clock/data and deframes 11-bit frames with parity, stop and timeout checks. Decodes set-2 scancodes, including E0/F0 prefixes, left/right shift and ctrl, into Apple-style 8-bit codes (bit 7 = strobe). Buffers them in a FIFO read by the CPU keyboard port. Sits between the PS/2 pins and the system bus, all in the `clock` domain.

---
 rtl/ps2_kbd_rx.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver, set-2 scancode decoder and character FIFO
module ps2_kbd_rx #(
    parameter int FILTER_LEN  = 16,
    parameter int TIMEOUT_CYC = 5000,
    parameter int FIFO_DEPTH  = 8,
    parameter int ERR_W       = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ps2_clk_in,
    input  logic                          ps2_dat_in,
    input  logic                          clr,
    output logic [7:0]                    kbd,
    output logic                          kbd_strb,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [ERR_W-1:0]              parity_err_cnt,
    output logic [ERR_W-1:0]              frame_err_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    function automatic logic [5:0] letter(input logic [7:0] b);
        case (b)
            8'h1C: letter = {1'b1, 5'd0};  8'h32: letter = {1'b1, 5'd1};  8'h21: letter = {1'b1, 5'd2};
            8'h23: letter = {1'b1, 5'd3};  8'h24: letter = {1'b1, 5'd4};  8'h2B: letter = {1'b1, 5'd5};
            8'h34: letter = {1'b1, 5'd6};  8'h33: letter = {1'b1, 5'd7};  8'h43: letter = {1'b1, 5'd8};
            8'h3B: letter = {1'b1, 5'd9};  8'h42: letter = {1'b1, 5'd10}; 8'h4B: letter = {1'b1, 5'd11};
            8'h3A: letter = {1'b1, 5'd12}; 8'h31: letter = {1'b1, 5'd13}; 8'h44: letter = {1'b1, 5'd14};
            8'h4D: letter = {1'b1, 5'd15}; 8'h15: letter = {1'b1, 5'd16}; 8'h2D: letter = {1'b1, 5'd17};
            8'h1B: letter = {1'b1, 5'd18}; 8'h2C: letter = {1'b1, 5'd19}; 8'h3C: letter = {1'b1, 5'd20};
            8'h2A: letter = {1'b1, 5'd21}; 8'h1D: letter = {1'b1, 5'd22}; 8'h22: letter = {1'b1, 5'd23};
            8'h35: letter = {1'b1, 5'd24}; 8'h1A: letter = {1'b1, 5'd25};
            default: letter = 6'd0;
        endcase
    endfunction

    // {mapped, character}; shifted codes with no shift entry fall through to the plain map
    function automatic logic [8:0] xlat(input logic [7:0] b, input logic e, input logic c, input logic s);
        logic [5:0] l;
        l = letter(b);
        xlat = 9'd0;
        if (e)
            xlat = b == 8'h6B ? 9'h188 : b == 8'h74 ? 9'h195 : 9'h0;
        else if (c && l[5])
            xlat = {1'b1, 8'h81 + {3'b0, l[4:0]}};
        else begin
            if (s)
                case (b)
                    8'h16: xlat = 9'h1A1; 8'h1E: xlat = 9'h1C0; 8'h26: xlat = 9'h1A3; 8'h25: xlat = 9'h1A4;
                    8'h2E: xlat = 9'h1A5; 8'h36: xlat = 9'h1DE; 8'h3D: xlat = 9'h1A6; 8'h3E: xlat = 9'h1AA;
                    8'h46: xlat = 9'h1A8; 8'h45: xlat = 9'h1A9; 8'h55: xlat = 9'h1AB; 8'h52: xlat = 9'h1A2;
                    8'h4C: xlat = 9'h1BA; 8'h41: xlat = 9'h1BC; 8'h49: xlat = 9'h1BE; 8'h4A: xlat = 9'h1BF;
                    default: xlat = 9'h0;
                endcase
            if (!xlat[8])
                case (b)
                    8'h45: xlat = 9'h1B0; 8'h16: xlat = 9'h1B1; 8'h1E: xlat = 9'h1B2; 8'h26: xlat = 9'h1B3;
                    8'h25: xlat = 9'h1B4; 8'h2E: xlat = 9'h1B5; 8'h36: xlat = 9'h1B6; 8'h3D: xlat = 9'h1B7;
                    8'h3E: xlat = 9'h1B8; 8'h46: xlat = 9'h1B9; 8'h52: xlat = 9'h1A7; 8'h55: xlat = 9'h1BD;
                    8'h4C: xlat = 9'h1BB; 8'h41: xlat = 9'h1AC; 8'h4E: xlat = 9'h1AD; 8'h49: xlat = 9'h1AE;
                    8'h4A: xlat = 9'h1AF; 8'h29: xlat = 9'h1A0; 8'h5A: xlat = 9'h18D; 8'h76: xlat = 9'h19B;
                    8'h66: xlat = 9'h188;
                    default: xlat = l[5] ? {1'b1, 8'hC1 + {3'b0, l[4:0]}} : 9'h0;
                endcase
        end
    endfunction

    logic [1:0] raw, filt;
    logic       clk_prev, fall;
    assign raw = {ps2_dat_in, ps2_clk_in};
    for (genvar i = 0; i < 2; i++) begin : g_flt
        logic [1:0] sy;
        logic [7:0] cnt;
        logic       f;
        always_ff @(posedge clock)
            if (reset) begin
                sy  <= 2'b11;
                cnt <= '0;
                f   <= 1'b1;
            end else begin
                sy <= {sy[0], raw[i]};
                if (sy[1] == f)
                    cnt <= '0;
                else if (cnt == 8'(FILTER_LEN - 1)) begin
                    cnt <= '0;
                    f   <= sy[1];
                end else
                    cnt <= cnt + 8'd1;
            end
        assign filt[i] = f;
    end
    always_ff @(posedge clock) clk_prev <= reset ? 1'b1 : filt[0];
    assign fall = clk_prev & ~filt[0];

    state_t          state, state_n;
    logic [2:0]      idx;
    logic [7:0]      sh;
    logic            par, good, perr, ferr, byte_valid;
    logic [TW-1:0]   tmo;
    always_comb begin
        state_n = state;
        good    = 1'b0;
        perr    = 1'b0;
        ferr    = 1'b0;
        if (fall)
            case (state)
                IDLE:   begin state_n = filt[1] ? IDLE : DATA; ferr = filt[1]; end
                DATA:   state_n = idx == 3'd7 ? PARITY : DATA;
                PARITY: state_n = STOP;
                STOP:   begin
                    state_n = IDLE;
                    good    = filt[1] & ^{par, sh};
                    perr    = filt[1] & ~^{par, sh};
                    ferr    = ~filt[1];
                end
                default: state_n = IDLE;
            endcase
        else if (state != IDLE && tmo == TW'(TIMEOUT_CYC - 1)) begin
            state_n = IDLE;
            ferr    = 1'b1;
        end
    end
    always_ff @(posedge clock)
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            sh             <= '0;
            par            <= 1'b0;
            tmo            <= '0;
            byte_valid     <= 1'b0;
            parity_err_cnt <= '0;
            frame_err_cnt  <= '0;
        end else begin
            state      <= state_n;
            byte_valid <= good;
            tmo        <= (fall || state_n == IDLE) ? '0 : tmo + TW'(1);
            if (fall && state == IDLE) idx <= '0;
            if (fall && state == DATA) begin
                sh  <= {filt[1], sh[7:1]};
                idx <= idx + 3'd1;
            end
            if (fall && state == PARITY) par <= filt[1];
            if (perr && ~&parity_err_cnt) parity_err_cnt <= parity_err_cnt + ERR_W'(1);
            if (ferr && ~&frame_err_cnt) frame_err_cnt <= frame_err_cnt + ERR_W'(1);
        end

    logic       brk, ext, lshift, rshift, ctrl, emit;
    logic [6:0] emit_ch;
    logic [8:0] x;
    assign x = xlat(sh, ext, ctrl, lshift | rshift);
    always_ff @(posedge clock)
        if (reset) begin
            {brk, ext, lshift, rshift, ctrl, emit} <= '0;
            emit_ch <= '0;
        end else begin
            emit    <= 1'b0;
            emit_ch <= x[6:0];
            if (byte_valid) begin
                if (sh == 8'hE0)
                    ext <= 1'b1;
                else if (sh == 8'hF0)
                    brk <= 1'b1;
                else if (brk) begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (sh == 8'h12) lshift <= 1'b0;
                    if (sh == 8'h59) rshift <= 1'b0;
                    if (sh == 8'h14) ctrl <= 1'b0;
                end else if (sh == 8'h12)
                    lshift <= 1'b1;
                else if (sh == 8'h59)
                    rshift <= 1'b1;
                else if (sh == 8'h14)
                    ctrl <= 1'b1;
                else begin
                    emit <= x[8];
                    ext  <= 1'b0;
                end
            end
        end

    logic [6:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [6:0]    last;
    logic          pop, full, wr;
    assign pop  = clr && fifo_level != '0;
    assign full = fifo_level == (AW + 1)'(FIFO_DEPTH);
    assign wr   = emit && (!full || pop);
    always_ff @(posedge clock) if (wr) mem[wp] <= emit_ch;
    always_ff @(posedge clock)
        if (reset) begin
            wp         <= '0;
            rp         <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            last       <= '0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (pop) begin
                rp   <= rp + AW'(1);
                last <= mem[rp];
            end
            fifo_level <= fifo_level + (AW + 1)'(wr) - (AW + 1)'(pop);
            if (emit && full && !pop) overflow <= 1'b1;
        end
    assign kbd_strb = fifo_level != '0;
    assign kbd      = {kbd_strb, kbd_strb ? mem[rp] : last};
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed table-driven bench for the PS/2 keyboard receiver
module tb_ps2_kbd_rx;
    localparam int FL = 4, TO = 100, FD = 4, EW = 3, H = 12;

    logic          clock = 1'b0, reset = 1'b1, ps2_clk_in = 1'b1, ps2_dat_in = 1'b1, clr = 1'b0;
    logic [7:0]    kbd;
    logic          kbd_strb, overflow;
    logic [2:0]    fifo_level;
    logic [EW-1:0] parity_err_cnt, frame_err_cnt;
    int            checks = 0, passed = 0;

    typedef struct {
        logic [63:0] codes;
        int          n;
        logic [31:0] exp;
        int          nexp;
    } vec_t;
    vec_t vecs[8];

    ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(FD), .ERR_W(EW)) dut (
        .clock(clock), .reset(reset), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in), .clr(clr),
        .kbd(kbd), .kbd_strb(kbd_strb), .fifo_level(fifo_level), .overflow(overflow),
        .parity_err_cnt(parity_err_cnt), .frame_err_cnt(frame_err_cnt)
    );

    always #5 clock = ~clock;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic pop();
        clr = 1'b1;
        wait_cyc(1);
        clr = 1'b0;
    endtask

    // mode 1: clr pulse lands on the FIFO write cycle; mode 2: check strobe rises exactly at E+3
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop, input int nbits, input int mode);
        logic [10:0] f;
        f = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat_in = f[i];
            wait_cyc(H / 2);
            ps2_clk_in = 1'b0;
            if (i == 10 && mode != 0) begin
                wait_cyc(8);
                if (mode == 1) clr = 1'b1;
                else chk("strb_before_e3", kbd_strb, 0);
                wait_cyc(1);
                if (mode == 1) clr = 1'b0;
                else chk("strb_at_e3", kbd_strb, 1);
                wait_cyc(H - 9);
            end else
                wait_cyc(H);
            ps2_clk_in = 1'b1;
            wait_cyc(H / 2);
        end
        ps2_dat_in = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11, 0);
    endtask

    initial begin
        logic [7:0] e;
        vecs[0] = '{64'h1CF01C,           3, 32'hC1,     1};
        vecs[1] = '{64'h1216F01216,       5, 32'hA1B1,   2};
        vecs[2] = '{64'h141CF014E06BE074, 8, 32'h818895, 3};
        vecs[3] = '{64'h77E075,           3, 32'h0,      0};
        vecs[4] = '{64'h45295A,           3, 32'hB0A08D, 3};
        vecs[5] = '{64'h5952F05952,       5, 32'hA2A7,   2};
        vecs[6] = '{64'h1416F014,         4, 32'hB1,     1};
        vecs[7] = '{64'h121EF012,         4, 32'hC0,     1};

        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(1);
        chk("rst_kbd", kbd, 0);
        chk("rst_strb", kbd_strb, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err_cnt, 0);
        chk("rst_perr", parity_err_cnt, 0);

        send_frame(8'h1C, 1'b0, 1'b1, 11, 2);
        chk("first_kbd", kbd, 32'hC1);
        pop();
        chk("first_pop_kbd", kbd, 32'h41);
        chk("first_pop_strb", kbd_strb, 0);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < vecs[v].n; i++) send(vecs[v].codes[8 * (vecs[v].n - 1 - i) +: 8]);
            chk($sformatf("v%0d_level", v), fifo_level, vecs[v].nexp);
            for (int j = 0; j < vecs[v].nexp; j++) begin
                e = vecs[v].exp[8 * (vecs[v].nexp - 1 - j) +: 8];
                chk($sformatf("v%0d_char%0d", v, j), kbd, e);
                pop();
            end
            chk($sformatf("v%0d_empty", v), kbd_strb, 0);
            if (vecs[v].nexp > 0) chk($sformatf("v%0d_last", v), kbd, {25'd0, e[6:0]});
        end

        send_frame(8'h1C, 1'b1, 1'b1, 11, 0);
        chk("par_cnt", parity_err_cnt, 1);
        chk("par_level", fifo_level, 0);
        send_frame(8'h1C, 1'b0, 1'b0, 11, 0);
        chk("stop_ferr", frame_err_cnt, 1);
        chk("stop_level", fifo_level, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 4, 0);
        wait_cyc(TO + 20);
        chk("tmo_ferr", frame_err_cnt, 2);
        send(8'h1C);
        chk("tmo_next_level", fifo_level, 1);
        chk("tmo_next_kbd", kbd, 32'hC1);
        pop();

        for (int g = 0; g < 5; g++) begin
            ps2_clk_in = 1'b0;
            wait_cyc(FL - 1);
            ps2_clk_in = 1'b1;
            wait_cyc(20);
        end
        chk("glitch_ferr", frame_err_cnt, 2);
        send(8'h32);
        chk("glitch_next_kbd", kbd, 32'hC2);
        pop();

        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        chk("ovf_level", fifo_level, FD);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", kbd, 32'hC1);
        send_frame(8'h2B, 1'b0, 1'b1, 11, 1);
        chk("pp_level", fifo_level, FD);
        chk("pp_ovf", overflow, 1);
        foreach (vecs[k]) if (k < 4) begin
            e = k == 0 ? 8'hC2 : k == 1 ? 8'hC3 : k == 2 ? 8'hC4 : 8'hC6;
            chk($sformatf("pp_char%0d", k), kbd, e);
            pop();
        end
        chk("pp_empty", kbd_strb, 0);
        chk("pp_last", kbd, 32'h46);

        for (int p = 0; p < 9; p++) begin
            ps2_clk_in = 1'b0;
            wait_cyc(H);
            ps2_clk_in = 1'b1;
            wait_cyc(H);
        end
        chk("sat_ferr", frame_err_cnt, 7);

        send(8'h1C);
        send_frame(8'h32, 1'b0, 1'b1, 4, 0);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        chk("mid_rst_kbd", kbd, 0);
        chk("mid_rst_strb", kbd_strb, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_ferr", frame_err_cnt, 0);
        chk("mid_rst_perr", parity_err_cnt, 0);
        wait_cyc(10);
        send(8'h16);
        chk("post_rst_level", fifo_level, 1);
        chk("post_rst_kbd", kbd, 32'hB1);
        chk("post_rst_ferr", frame_err_cnt, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
